// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational 16-bit ALU between two independent requesters.
// One operation is in flight at a time:
//   IDLE : pick a winner and accept its request.
//          The operands and opcode are registered onto the ALU inputs.
//   EXEC : the ALU settles. Its result and status are captured at the end
//          of this cycle.
//   RESP : the captured result is offered to the winner until it takes it.
// The block does no arithmetic itself. It only sequences and holds the
// ALU inputs and outputs.
//
// Optional feature macro: ALU_ARB_RR_EN
//   defined   : round-robin arbitration on contention.
//   undefined : fixed priority, where requester 0 always wins on contention.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   rN_req_valid / rN_req_ready  request handshake, N = 0,1
//   rN_ain, rN_bin, rN_op        operands and opcode
//                                (00 add, 01 sub, 10 and, 11 negate B)
//   rN_rsp_valid / rN_rsp_ready  response handshake, N = 0,1
//   rsp_data, rsp_status         shared result bus and {N,V,Z} status
//   alu_ain, alu_bin, alu_op     registered drive to the ALU
//   alu_out, alu_status          combinational ALU result and status
//   busy                         high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module alu_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  // requester 0
  input  logic        r0_req_valid,
  output logic        r0_req_ready,
  input  logic [15:0] r0_ain,
  input  logic [15:0] r0_bin,
  input  logic [1:0]  r0_op,
  output logic        r0_rsp_valid,
  input  logic        r0_rsp_ready,
  // requester 1
  input  logic        r1_req_valid,
  output logic        r1_req_ready,
  input  logic [15:0] r1_ain,
  input  logic [15:0] r1_bin,
  input  logic [1:0]  r1_op,
  output logic        r1_rsp_valid,
  input  logic        r1_rsp_ready,
  // shared response bus
  output logic [15:0] rsp_data,
  output logic [2:0]  rsp_status,
  // ALU connection
  output logic [15:0] alu_ain,
  output logic [15:0] alu_bin,
  output logic [1:0]  alu_op,
  input  logic [15:0] alu_out,
  input  logic [2:0]  alu_status,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_grant;        // requester that owns the in-flight operation
  logic [15:0] r_alu_ain;
  logic [15:0] r_alu_bin;
  logic [1:0]  r_alu_op;
  logic [15:0] r_rsp_data;
  logic [2:0]  r_rsp_status;

  logic        w_any_valid;
  logic        w_winner;
  logic        w_accept;
  logic        w_rsp_hs;
  logic [15:0] w_sel_ain;
  logic [15:0] w_sel_bin;
  logic [1:0]  w_sel_op;

  assign w_any_valid = r0_req_valid | r1_req_valid;

`ifdef ALU_ARB_RR_EN
  logic r_last_grant;

  // On contention, the requester that did not win last time goes first.
  // last_grant resets to 1, so requester 0 wins the first contention.
  assign w_winner = (r0_req_valid && r1_req_valid) ? ~r_last_grant
                                                   : ~r0_req_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_last_grant <= 1'b1;
    else if (w_accept) r_last_grant <= w_winner;
  end
`else
  // Requester 0 wins whenever it is valid. Requester 1 may starve.
  assign w_winner = ~r0_req_valid;
`endif

  // Accept only from IDLE. Ready is also masked while reset_n is low,
  // so no request is taken during reset.
  assign w_accept = reset_n && (r_state == ST_IDLE) && w_any_valid;

  // Only the granted requester's rsp_ready matters.
  assign w_rsp_hs = (r_state == ST_RESP) &&
                    (r_grant ? r1_rsp_ready : r0_rsp_ready);

  assign w_sel_ain = w_winner ? r1_ain : r0_ain;
  assign w_sel_bin = w_winner ? r1_bin : r0_bin;
  assign w_sel_op  = w_winner ? r1_op  : r0_op;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    r0_req_ready = 1'b0;
    r1_req_ready = 1'b0;
    r0_rsp_valid = 1'b0;
    r1_rsp_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          r0_req_ready = ~w_winner;
          r1_req_ready =  w_winner;
          w_state_nxt  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        r0_rsp_valid = ~r_grant;
        r1_rsp_valid =  r_grant;
        // No accept in the handshake cycle. IDLE is entered first.
        if (w_rsp_hs) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // The ALU inputs hold their last value outside an accept.
  // The result registers change only at the end of EXEC, so they stay
  // frozen throughout RESP back-pressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant      <= 1'b0;
      r_alu_ain    <= '0;
      r_alu_bin    <= '0;
      r_alu_op     <= '0;
      r_rsp_data   <= '0;
      r_rsp_status <= '0;
    end else begin
      if (w_accept) begin
        r_grant   <= w_winner;
        r_alu_ain <= w_sel_ain;
        r_alu_bin <= w_sel_bin;
        r_alu_op  <= w_sel_op;
      end
      if (r_state == ST_EXEC) begin
        r_rsp_data   <= alu_out;
        r_rsp_status <= alu_status;
      end
    end
  end

  assign alu_ain    = r_alu_ain;
  assign alu_bin    = r_alu_bin;
  assign alu_op     = r_alu_op;
  assign rsp_data   = r_rsp_data;
  assign rsp_status = r_rsp_status;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter.
// A behavioural 16-bit ALU (add/sub/and/negate with {N,V,Z}) is attached to
// the arbiter's ALU ports. Expected results are hand-computed constants.
// The grant-order expectations follow ALU_ARB_RR_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  logic        clk;
  logic        reset_n;
  logic        r0_req_valid, r0_req_ready, r0_rsp_valid, r0_rsp_ready;
  logic [15:0] r0_ain, r0_bin;
  logic [1:0]  r0_op;
  logic        r1_req_valid, r1_req_ready, r1_rsp_valid, r1_rsp_ready;
  logic [15:0] r1_ain, r1_bin;
  logic [1:0]  r1_op;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_status;
  logic [15:0] alu_ain, alu_bin, alu_out;
  logic [1:0]  alu_op;
  logic [2:0]  alu_status;
  logic        busy;

  int n_checks   = 0;
  int n_failures = 0;

  alu_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .r0_req_valid (r0_req_valid),
    .r0_req_ready (r0_req_ready),
    .r0_ain       (r0_ain),
    .r0_bin       (r0_bin),
    .r0_op        (r0_op),
    .r0_rsp_valid (r0_rsp_valid),
    .r0_rsp_ready (r0_rsp_ready),
    .r1_req_valid (r1_req_valid),
    .r1_req_ready (r1_req_ready),
    .r1_ain       (r1_ain),
    .r1_bin       (r1_bin),
    .r1_op        (r1_op),
    .r1_rsp_valid (r1_rsp_valid),
    .r1_rsp_ready (r1_rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_status   (rsp_status),
    .alu_ain      (alu_ain),
    .alu_bin      (alu_bin),
    .alu_op       (alu_op),
    .alu_out      (alu_out),
    .alu_status   (alu_status),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational ALU
  logic [15:0] m_r;
  logic        m_v;
  always_comb begin
    m_r = '0;
    m_v = 1'b0;
    case (alu_op)
      2'b00: begin
        m_r = alu_ain + alu_bin;
        m_v = (alu_ain[15] == alu_bin[15]) && (m_r[15] != alu_ain[15]);
      end
      2'b01: begin
        m_r = alu_ain - alu_bin;
        m_v = (alu_ain[15] != alu_bin[15]) && (m_r[15] != alu_ain[15]);
      end
      2'b10: begin
        m_r = alu_ain & alu_bin;
        m_v = 1'b0;
      end
      default: begin
        m_r = ~alu_bin + 16'd1;
        m_v = (alu_bin == 16'h8000);
      end
    endcase
  end
  assign alu_out    = m_r;
  assign alu_status = {m_r[15], m_v, (m_r == 16'h0000)};

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp,
               $time);
    end
  endtask

  typedef struct {
    logic        req;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_data;
    logic [2:0]  exp_status;
  } vec_t;

  vec_t vecs[8];

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   accepts;
    int   last_cyc;
    int   rsp_seen;
    logic [3:0] exp_order;

    // {req, op, a, b, data, status{N,V,Z}}
    vecs[0] = '{1'b0, 2'b01, 16'h0005, 16'h0005, 16'h0000, 3'b001};
    vecs[1] = '{1'b1, 2'b11, 16'h0000, 16'h0001, 16'hFFFF, 3'b100};
    vecs[2] = '{1'b0, 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 3'b110};
    vecs[3] = '{1'b1, 2'b10, 16'hF0F0, 16'hFF00, 16'hF000, 3'b100};
    vecs[4] = '{1'b0, 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 3'b001};
    vecs[5] = '{1'b1, 2'b01, 16'h8000, 16'h0001, 16'h7FFF, 3'b010};
    vecs[6] = '{1'b0, 2'b11, 16'h0000, 16'h8000, 16'h8000, 3'b110};
    vecs[7] = '{1'b0, 2'b10, 16'h1234, 16'h0000, 16'h0000, 3'b001};

    reset_n      = 1'b0;
    r0_req_valid = 1'b1;  // ready must stay low during reset anyway
    r1_req_valid = 1'b1;
    r0_ain = 16'h1111; r0_bin = 16'h2222; r0_op = 2'b00;
    r1_ain = 16'h3333; r1_bin = 16'h4444; r1_op = 2'b00;
    r0_rsp_ready = 1'b0;
    r1_rsp_ready = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_r0_req_ready", {31'd0, r0_req_ready}, 0);
    check("rst_r1_req_ready", {31'd0, r1_req_ready}, 0);
    check("rst_rsp_valid",    {30'd0, r0_rsp_valid, r1_rsp_valid}, 0);
    check("rst_rsp_data",     {16'd0, rsp_data}, 0);
    check("rst_rsp_status",   {29'd0, rsp_status}, 0);
    check("rst_alu_ain",      {16'd0, alu_ain}, 0);
    check("rst_alu_bin",      {16'd0, alu_bin}, 0);
    check("rst_alu_op",       {30'd0, alu_op}, 0);
    check("rst_busy",         {31'd0, busy}, 0);
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b0;
    reset_n      = 1'b1;
    @(posedge clk); #1;

    // ---------------- table-driven single transactions ----------------
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      if (v.req) begin
        r1_req_valid = 1'b1; r1_ain = v.a; r1_bin = v.b; r1_op = v.op;
      end else begin
        r0_req_valid = 1'b1; r0_ain = v.a; r0_bin = v.b; r0_op = v.op;
      end
      @(negedge clk);  // cycle T
      check("vec_ready",       {31'd0, (v.req ? r1_req_ready : r0_req_ready)}, 1);
      check("vec_other_ready", {31'd0, (v.req ? r0_req_ready : r1_req_ready)}, 0);
      @(posedge clk); #1;
      r0_req_valid = 1'b0;
      r1_req_valid = 1'b0;
      @(negedge clk);  // T+1, EXEC
      check("vec_exec_busy",  {31'd0, busy}, 1);
      check("vec_exec_nornd", {30'd0, r0_rsp_valid, r1_rsp_valid}, 0);
      check("vec_alu_ain",    {16'd0, alu_ain}, {16'd0, v.a});
      check("vec_alu_bin",    {16'd0, alu_bin}, {16'd0, v.b});
      check("vec_alu_op",     {30'd0, alu_op},  {30'd0, v.op});
      @(posedge clk); #1;
      @(negedge clk);  // T+2, RESP
      check("vec_rsp_valid", {30'd0, r1_rsp_valid, r0_rsp_valid},
            v.req ? 32'd2 : 32'd1);
      check("vec_rsp_data",   {16'd0, rsp_data},   {16'd0, v.exp_data});
      check("vec_rsp_status", {29'd0, rsp_status}, {29'd0, v.exp_status});
      if (v.req) r1_rsp_ready = 1'b1;
      else       r0_rsp_ready = 1'b1;
      @(posedge clk); #1;
      r0_rsp_ready = 1'b0;
      r1_rsp_ready = 1'b0;
      @(negedge clk);
      check("vec_after_valid", {30'd0, r0_rsp_valid, r1_rsp_valid}, 0);
      check("vec_after_busy",  {31'd0, busy}, 0);
      @(posedge clk); #1;
    end

    // ---------------- back-pressure with r1 waiting ----------------
    r0_req_valid = 1'b1; r0_ain = 16'hF0F0; r0_bin = 16'hFF00; r0_op = 2'b10;
    r1_ain = 16'h0003; r1_bin = 16'h0004; r1_op = 2'b00;
    @(negedge clk);
    check("bp_r0_ready", {31'd0, r0_req_ready}, 1);
    @(posedge clk); #1;
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b1;
    r1_rsp_ready = 1'b1;  // non-granted rsp_ready must be ignored
    @(negedge clk);  // EXEC
    check("bp_exec_r1_ready", {31'd0, r1_req_ready}, 0);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_hold_valid",  {30'd0, r1_rsp_valid, r0_rsp_valid}, 1);
      check("bp_hold_data",   {16'd0, rsp_data}, 32'hF000);
      check("bp_hold_status", {29'd0, rsp_status}, 32'h4);
      check("bp_hold_r1_rdy", {31'd0, r1_req_ready}, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    r0_rsp_ready = 1'b1;
    #1;
    check("bp_hs_r1_ready", {31'd0, r1_req_ready}, 0);
    @(posedge clk); #1;
    r0_rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_r1_accept", {31'd0, r1_req_ready}, 1);
    check("bp_r0_dropped", {31'd0, r0_rsp_valid}, 0);
    @(posedge clk); #1;
    r1_req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_r1_rsp_valid", {30'd0, r1_rsp_valid, r0_rsp_valid}, 2);
    check("bp_r1_rsp_data",  {16'd0, rsp_data}, 32'h0007);
    check("bp_r1_status",    {29'd0, rsp_status}, 0);
    @(posedge clk); #1;  // handshake with r1_rsp_ready = 1
    r1_rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_end_busy", {31'd0, busy}, 0);

    // ---------------- reset during EXEC ----------------
    @(posedge clk); #1;
    r0_req_valid = 1'b1; r0_ain = 16'h0100; r0_bin = 16'h0200; r0_op = 2'b00;
    @(negedge clk);
    check("rx_r0_ready", {31'd0, r0_req_ready}, 1);
    @(posedge clk); #1;
    r0_req_valid = 1'b0;
    #1;
    check("rx_in_exec", {31'd0, busy}, 1);
    reset_n = 1'b0;
    #1;
    check("rx_busy",     {31'd0, busy}, 0);
    check("rx_alu_ain",  {16'd0, alu_ain}, 0);
    check("rx_alu_bin",  {16'd0, alu_bin}, 0);
    check("rx_rsp_data", {16'd0, rsp_data}, 0);
    check("rx_rsp_vld",  {30'd0, r0_rsp_valid, r1_rsp_valid}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    rsp_seen = 0;
    r0_rsp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (r0_rsp_valid) rsp_seen++;
    end
    check("rx_no_response", rsp_seen, 0);

    // ---------------- continuous contention ----------------
`ifdef ALU_ARB_RR_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b0000;
`endif
    @(posedge clk); #1;
    r0_req_valid = 1'b1; r0_ain = 16'h0001; r0_bin = 16'h0002; r0_op = 2'b00;
    r1_req_valid = 1'b1; r1_ain = 16'h000A; r1_bin = 16'h0014; r1_op = 2'b00;
    r0_rsp_ready = 1'b1;
    r1_rsp_ready = 1'b1;
    accepts  = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 20 && accepts < 4; cyc++) begin
      @(negedge clk);
      check("ct_one_ready", {31'd0, r0_req_ready & r1_req_ready}, 0);
      if (r0_rsp_valid) check("ct_r0_data", {16'd0, rsp_data}, 32'h0003);
      if (r1_rsp_valid) check("ct_r1_data", {16'd0, rsp_data}, 32'h001E);
      if (r0_req_ready || r1_req_ready) begin
        check("ct_grant", {31'd0, r1_req_ready}, {31'd0, exp_order[accepts]});
        if (accepts > 0) check("ct_interval", cyc - last_cyc, 3);
        last_cyc = cyc;
        accepts++;
      end
    end
    check("ct_accepts", accepts, 4);
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b0;
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
